// File: rtl/lcd_rx_pkg.sv
// Shared state encoding, default panel timing and counter widths for the
// DE-mode LCD receiver.
package lcd_rx_pkg;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_VBLANK = 2'd1,
        ST_ACTIVE = 2'd2
    } rx_state_t;

    localparam int DEF_H_ACTIVE  = 480;
    localparam int DEF_V_ACTIVE  = 272;
    localparam int DEF_V_GAP_MIN = 1024;

    localparam int GAP_W = 11;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int PIX_W = 16;

    localparam logic [GAP_W-1:0] GAP_MAX = '1;
    localparam logic [X_W-1:0]   X_MAX   = '1;
    localparam logic [Y_W-1:0]   Y_MAX   = '1;

endpackage

// File: rtl/lcd_rx_lock.sv
// Per-line and per-frame measurement, sticky geometry errors and the
// two-good-frames lock detector.
module lcd_rx_lock
    import lcd_rx_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic           PixelClk,
    input  logic           nRST,
    input  logic           line_end,
    input  logic [X_W-1:0] line_len,
    input  logic           frame_end,
    input  logic [Y_W-1:0] frame_lines,
    input  logic           err_clr,
    output logic           frame_done,
    output logic [X_W-1:0] meas_width,
    output logic [Y_W-1:0] meas_height,
    output logic           locked,
    output logic           err_width,
    output logic           err_height
);

    logic [X_W-1:0] last_len;
    logic [X_W-1:0] cur_len;
    logic           wbad_frame;
    logic           prev_good;
    logic           line_bad;
    logic           frame_good;
    logic           set_h;

    // A line closing on the same cycle as the frame still counts toward it.
    always_comb begin
        line_bad   = line_end && (line_len != X_W'(H_ACTIVE));
        cur_len    = line_end ? line_len : last_len;
        frame_good = !(wbad_frame || line_bad) && (frame_lines == Y_W'(V_ACTIVE));
        set_h      = frame_end && (frame_lines != Y_W'(V_ACTIVE));
    end

    always_ff @(posedge PixelClk) begin
        if (!nRST) begin
            frame_done  <= 1'b0;
            meas_width  <= '0;
            meas_height <= '0;
            locked      <= 1'b0;
            err_width   <= 1'b0;
            err_height  <= 1'b0;
            last_len    <= '0;
            wbad_frame  <= 1'b0;
            prev_good   <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (line_end)
                last_len <= line_len;
            // set beats clear when both land on the same edge
            err_width  <= line_bad || (err_width && !err_clr);
            err_height <= set_h || (err_height && !err_clr);
            if (frame_end) begin
                meas_width  <= cur_len;
                meas_height <= frame_lines;
                locked      <= frame_good && prev_good;
                prev_good   <= frame_good;
                wbad_frame  <= 1'b0;
            end else if (line_bad) begin
                wbad_frame <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_de_rx.sv
// DE-mode RGB565 receiver: two-stage sampling, vertical-blank tracking FSM,
// pixel coordinate counters; measurement and lock live in lcd_rx_lock.
module lcd_de_rx
    import lcd_rx_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_GAP_MIN = DEF_V_GAP_MIN
) (
    input  logic             PixelClk,
    input  logic             nRST,
    input  logic             LCD_DE,
    input  logic [4:0]       LCD_R,
    input  logic [5:0]       LCD_G,
    input  logic [4:0]       LCD_B,
    input  logic             err_clr,
    output logic             pix_valid,
    output logic [PIX_W-1:0] pix_data,
    output logic [X_W-1:0]   pix_x,
    output logic [Y_W-1:0]   pix_y,
    output logic             pix_sof,
    output logic             pix_eol,
    output logic             frame_done,
    output logic [X_W-1:0]   meas_width,
    output logic [Y_W-1:0]   meas_height,
    output logic             locked,
    output logic             err_width,
    output logic             err_height
);

    localparam logic [GAP_W-1:0] GAP_MIN = GAP_W'(V_GAP_MIN);

    rx_state_t        state, state_nxt;
    logic             s1_vld;
    logic             de_s1, de_s2, de_s3;
    logic [PIX_W-1:0] rgb_s1, rgb_s2;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic             frame_end, frame_end_q;
    logic             sof_pend;
    logic [Y_W-1:0]   line_cnt, line_cnt_nxt;
    logic             pix_ok, line_rise;
    logic [X_W-1:0]   x_nxt, line_len;
    logic [Y_W-1:0]   y_nxt;

    // s1_vld keeps the post-reset empty stage from counting as a low sample.
    always_ff @(posedge PixelClk) begin
        if (!nRST) begin
            s1_vld      <= 1'b0;
            de_s1       <= 1'b0;
            de_s2       <= 1'b0;
            de_s3       <= 1'b0;
            rgb_s1      <= '0;
            rgb_s2      <= '0;
            gap_cnt     <= '0;
            frame_end_q <= 1'b0;
        end else begin
            s1_vld      <= 1'b1;
            de_s1       <= LCD_DE;
            rgb_s1      <= {LCD_R, LCD_G, LCD_B};
            de_s2       <= de_s1;
            rgb_s2      <= rgb_s1;
            de_s3       <= de_s2;
            gap_cnt     <= gap_nxt;
            frame_end_q <= frame_end;
        end
    end

    always_comb begin
        gap_nxt = gap_cnt;
        if (s1_vld) begin
            if (de_s1)
                gap_nxt = '0;
            else if (gap_cnt != GAP_MAX)
                gap_nxt = gap_cnt + 1'b1;
        end
    end

    always_ff @(posedge PixelClk) begin
        if (!nRST)
            state <= ST_SYNC;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        frame_end = 1'b0;
        case (state)
            ST_SYNC:   if (gap_nxt == GAP_MIN) state_nxt = ST_VBLANK;
            ST_VBLANK: if (de_s1) state_nxt = ST_ACTIVE;
            ST_ACTIVE: begin
                if (gap_nxt == GAP_MIN) begin
                    state_nxt = ST_VBLANK;
                    frame_end = 1'b1;
                end
            end
            default:   state_nxt = ST_SYNC;
        endcase
    end

    // Stage 2: state already reflects the sample now in de_s2; de_s1 is its successor.
    always_comb begin
        pix_ok       = de_s2 && (state == ST_ACTIVE);
        line_rise    = de_s2 && !de_s3;
        x_nxt        = pix_x;
        y_nxt        = pix_y;
        line_cnt_nxt = line_cnt;
        if (line_rise) begin
            x_nxt = '0;
            if (sof_pend) begin
                y_nxt        = '0;
                line_cnt_nxt = Y_W'(1);
            end else begin
                if (pix_y != Y_MAX)    y_nxt        = pix_y + 1'b1;
                if (line_cnt != Y_MAX) line_cnt_nxt = line_cnt + 1'b1;
            end
        end else if (pix_x != X_MAX) begin
            x_nxt = pix_x + 1'b1;
        end
        line_len = (pix_x == X_MAX) ? pix_x : pix_x + 1'b1;
    end

    always_ff @(posedge PixelClk) begin
        if (!nRST) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            sof_pend  <= 1'b0;
            line_cnt  <= '0;
        end else begin
            pix_valid <= pix_ok;
            pix_sof   <= pix_ok && (x_nxt == '0) && (y_nxt == '0);
            pix_eol   <= pix_ok && !de_s1;
            if (pix_ok) begin
                pix_data <= rgb_s2;
                pix_x    <= x_nxt;
                pix_y    <= y_nxt;
                line_cnt <= line_cnt_nxt;
            end
            if (state != ST_ACTIVE)
                sof_pend <= 1'b1;
            else if (pix_ok)
                sof_pend <= 1'b0;
        end
    end

    lcd_rx_lock #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_lock (
        .PixelClk    (PixelClk),
        .nRST        (nRST),
        .line_end    (pix_eol),
        .line_len    (line_len),
        .frame_end   (frame_end_q),
        .frame_lines (line_cnt),
        .err_clr     (err_clr),
        .frame_done  (frame_done),
        .meas_width  (meas_width),
        .meas_height (meas_height),
        .locked      (locked),
        .err_width   (err_width),
        .err_height  (err_height)
    );

endmodule

// File: tb/tb_lcd_de_rx.sv
// Scoreboard bench for lcd_de_rx: the driver models the expected pixel and
// frame stream from the samples it drives; the monitor compares DUT output.
module tb_lcd_de_rx;

    localparam int H_ACT = 24;
    localparam int V_ACT = 6;
    localparam int VGAP  = 64;
    localparam int HGAP  = 5;
    localparam int VBL   = 100;

    typedef struct {
        logic [15:0] data;
        int          x;
        int          y;
        bit          sof;
        bit          eol;
        int          cyc;
    } pix_t;

    typedef struct {
        int cyc;
        int w;
        int h;
        bit lck;
        int npix;
    } frm_t;

    logic        PixelClk = 1'b0;
    logic        nRST = 1'b0;
    logic        LCD_DE = 1'b0;
    logic [4:0]  LCD_R = '0;
    logic [5:0]  LCD_G = '0;
    logic [4:0]  LCD_B = '0;
    logic        err_clr = 1'b0;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_sof, pix_eol, frame_done;
    logic [9:0]  meas_width;
    logic [8:0]  meas_height;
    logic        locked, err_width, err_height;

    lcd_de_rx #(
        .H_ACTIVE  (H_ACT),
        .V_ACTIVE  (V_ACT),
        .V_GAP_MIN (VGAP)
    ) dut (
        .PixelClk    (PixelClk),
        .nRST        (nRST),
        .LCD_DE      (LCD_DE),
        .LCD_R       (LCD_R),
        .LCD_G       (LCD_G),
        .LCD_B       (LCD_B),
        .err_clr     (err_clr),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_sof     (pix_sof),
        .pix_eol     (pix_eol),
        .frame_done  (frame_done),
        .meas_width  (meas_width),
        .meas_height (meas_height),
        .locked      (locked),
        .err_width   (err_width),
        .err_height  (err_height)
    );

    always #5 PixelClk = ~PixelClk;

    int cyc = 0;
    always @(posedge PixelClk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    // scoreboard and stream model state
    pix_t pq[$];
    frm_t fq[$];
    pix_t pend, e;
    frm_t fm;
    bit   pend_ok = 0, armed = 0, in_frame = 0, prev_de = 0, prev_good = 0, lens_bad = 0;
    bit   clr_on_end = 0;
    int   gap = 0, x_m = 0, y_m = 0, line_cur = 0, last_len = 0, frm_pix = 0;
    int   clr_plan = -1;
    int   npix_seen = 0;

    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    always @(negedge PixelClk) begin
        if (pix_valid) begin
            npix_seen++;
            chk("pix_expected", pq.size() != 0, 1);
            if (pq.size() != 0) begin
                e = pq.pop_front();
                chk("pix_cyc", cyc, e.cyc);
                chk("pix_data", pix_data, e.data);
                chk("pix_x", pix_x, e.x);
                chk("pix_y", pix_y, e.y);
                chk("pix_sof", pix_sof, e.sof);
                chk("pix_eol", pix_eol, e.eol);
            end
        end else begin
            chk("idle_flags", {pix_sof, pix_eol}, 2'b00);
        end
        if (frame_done) begin
            chk("frame_expected", fq.size() != 0, 1);
            if (fq.size() != 0) begin
                fm = fq.pop_front();
                chk("fd_cyc", cyc, fm.cyc);
                chk("meas_width", meas_width, fm.w);
                chk("meas_height", meas_height, fm.h);
                chk("fd_locked", locked, fm.lck);
                chk("frame_pixels", npix_seen, fm.npix);
            end
            npix_seen = 0;
        end
    end

    task automatic drive_sample(input bit de, input logic [15:0] d);
        bit   good;
        frm_t f;
        @(negedge PixelClk);
        #1;
        nRST = 1'b1;
        LCD_DE = de;
        {LCD_R, LCD_G, LCD_B} = d;
        err_clr = (clr_plan == 0);
        if (clr_plan >= 0) clr_plan--;
        if (pend_ok) begin
            pend.eol = !de;
            pq.push_back(pend);
            pend_ok = 0;
        end
        if (de) begin
            gap = 0;
            if (armed) begin
                if (!prev_de) begin
                    if (!in_frame) begin
                        y_m = 0;
                        in_frame = 1;
                    end else begin
                        y_m++;
                    end
                    x_m = 0;
                    line_cur = 0;
                end else begin
                    x_m++;
                end
                line_cur++;
                frm_pix++;
                pend.data = d;
                pend.x    = x_m;
                pend.y    = y_m;
                pend.sof  = (x_m == 0) && (y_m == 0);
                pend.eol  = 0;
                pend.cyc  = cyc + 3;
                pend_ok   = 1;
            end
        end else begin
            if (prev_de && armed && in_frame) begin
                last_len = line_cur;
                if (line_cur != H_ACT) lens_bad = 1;
            end
            if (gap < 2047) gap++;
            if (gap == VGAP) begin
                if (!armed) begin
                    armed = 1;
                end else if (in_frame) begin
                    good   = !lens_bad && (y_m + 1 == V_ACT);
                    f.cyc  = cyc + 3;
                    f.w    = last_len;
                    f.h    = y_m + 1;
                    f.lck  = good && prev_good;
                    f.npix = frm_pix;
                    fq.push_back(f);
                    prev_good = good;
                    in_frame  = 0;
                    lens_bad  = 0;
                    frm_pix   = 0;
                    if (clr_on_end) begin
                        clr_plan   = 1;
                        clr_on_end = 0;
                    end
                end
            end
        end
        prev_de = de;
    endtask

    task automatic drive_idle(input int n);
        repeat (n) drive_sample(1'b0, 16'h0000);
    endtask

    task automatic drive_pixels(input int from, input int to, input int mode);
        for (int i = from; i < to; i++)
            drive_sample(1'b1, mode == 1 ? bars[(i * 8) / H_ACT] : 16'($urandom));
    endtask

    task automatic drive_line(input int len, input int mode);
        drive_pixels(0, len, mode);
        drive_idle(HGAP);
    endtask

    task automatic drive_frame(input int nlines, input int short_line, input int mode);
        for (int l = 0; l < nlines; l++)
            drive_line(l == short_line ? H_ACT - 1 : H_ACT, mode);
        drive_idle(VBL);
    endtask

    task automatic do_reset();
        @(negedge PixelClk);
        #1;
        nRST = 1'b0;
        LCD_DE = 1'b0;
        err_clr = 1'b0;
        clr_plan = -1;
        clr_on_end = 0;
        pq.delete();
        fq.delete();
        pend_ok = 0; armed = 0; in_frame = 0; prev_de = 0;
        prev_good = 0; lens_bad = 0; gap = 0; frm_pix = 0;
        npix_seen = 0;
        @(negedge PixelClk);
        #1;
        chk("rst_pix", {pix_valid, pix_sof, pix_eol, pix_data, pix_x, pix_y}, 0);
        chk("rst_meas", {frame_done, meas_width, meas_height}, 0);
        chk("rst_flags", {locked, err_width, err_height}, 0);
    endtask

    initial begin
        do_reset();

        // first frame falls in SYNC; next two are measured and lock
        drive_frame(V_ACT, -1, 0);
        drive_frame(V_ACT, -1, 0);
        drive_frame(V_ACT, -1, 1);
        chk("lock_after_3", locked, 1);
        chk("no_err_w", err_width, 0);
        chk("no_err_h", err_height, 0);

        // one short line in a locked stream
        drive_frame(V_ACT, 2, 1);
        chk("short_line_err_w", err_width, 1);
        chk("short_line_err_h", err_height, 0);
        chk("short_line_unlock", locked, 0);
        clr_plan = 0;
        drive_idle(4);
        chk("err_w_cleared", err_width, 0);

        drive_frame(V_ACT, -1, 0);
        drive_frame(V_ACT, -1, 0);
        chk("relock", locked, 1);

        // missing line
        drive_frame(V_ACT - 1, -1, 0);
        chk("short_frame_err_h", err_height, 1);
        chk("short_frame_unlock", locked, 0);
        clr_plan = 0;
        drive_idle(4);
        chk("err_h_cleared", err_height, 0);

        // clear landing on the same edge as a new height error
        clr_on_end = 1;
        drive_frame(V_ACT - 1, -1, 0);
        chk("set_beats_clr", err_height, 1);

        // a VGAP-1 low run inside the frame must not end it
        for (int l = 0; l < 3; l++) drive_line(H_ACT, 0);
        drive_idle(VGAP - 1 - HGAP);
        for (int l = 3; l < V_ACT; l++) drive_line(H_ACT, 0);
        drive_idle(VBL);
        drive_frame(V_ACT, -1, 0);
        chk("lock_after_gap_frame", locked, 1);

        // reset in the middle of a line, then the partial frame is ignored
        for (int l = 0; l < 3; l++) drive_line(H_ACT, 0);
        drive_pixels(0, 10, 0);
        do_reset();
        drive_pixels(10, H_ACT, 0);
        drive_idle(HGAP);
        for (int l = 4; l < V_ACT; l++) drive_line(H_ACT, 0);
        drive_idle(VBL);
        drive_frame(V_ACT, -1, 1);
        drive_frame(V_ACT, -1, 0);
        chk("lock_after_reset", locked, 1);
        chk("final_err_w", err_width, 0);

        drive_idle(10);
        chk("pixq_empty", pq.size(), 0);
        chk("frmq_empty", fq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lcd_de_rx.md
LCD_DE_RX -- requirements
Module: lcd_de_rx

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 480: expected active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 272: expected active lines per frame.
REQ-003 SHALL have parameter V_GAP_MIN, default 1024: minimum run of consecutive LCD_DE=0 samples that counts as vertical blanking.
REQ-004 SHALL have ports: PixelClk  in  1  pixel clock, the only clock.
REQ-005 SHALL have port nRST  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports LCD_DE in 1 data enable; LCD_R in 5; LCD_G in 6; LCD_B in 5: DE-mode RGB565 panel bus sampled on PixelClk.
REQ-007 SHALL have port err_clr  in  1  clears sticky error flags.
REQ-008 SHALL have ports pix_valid out 1; pix_data out 16 {R,G,B}; pix_x out 10; pix_y out 9; pix_sof out 1 first pixel of frame; pix_eol out 1 last pixel of line.
REQ-009 SHALL have ports frame_done out 1 one-cycle pulse; meas_width out 10; meas_height out 9; locked out 1; err_width out 1; err_height out 1.

Function
REQ-010 SHALL register LCD_DE and RGB on every PixelClk edge; all pixel outputs SHALL lag the sampling edge by exactly 2 cycles.
REQ-011 SHALL implement FSM SYNC, VBLANK, ACTIVE; SYNC entered from reset.
REQ-012 SYNC -> VBLANK when the gap counter reaches V_GAP_MIN; DE activity in SYNC SHALL produce no pix_valid.
REQ-013 VBLANK -> ACTIVE on the first sampled DE=1; VBLANK SHALL continue to ignore gap-counter growth.
REQ-014 ACTIVE -> VBLANK when the gap counter reaches V_GAP_MIN (frame end event).
REQ-015 Gap counter: 11 bits, cleared by DE=1, increments per DE=0 sample, saturates at 2047.
REQ-016 pix_valid SHALL equal the delayed DE only while in ACTIVE (including the DE rise that leaves VBLANK).
REQ-017 pix_x SHALL be 0 on the first pixel of each line, increment per valid pixel, saturate at 1023.
REQ-018 pix_y SHALL be 0 for the first line of a frame, increment on each DE rise within ACTIVE, saturate at 511.
REQ-019 pix_eol SHALL assert with the pixel whose next sample has DE=0; pix_sof with pixel x=0,y=0.
REQ-020 On frame end: frame_done pulses 2 cycles after the V_GAP_MIN-th low sample; meas_width = last completed line length; meas_height = line count, both updated in the same cycle.
REQ-021 A line whose length differs from H_ACTIVE SHALL set err_width; a frame whose line count differs from V_ACTIVE SHALL set err_height at frame_done.
REQ-022 err_* are sticky; err_clr clears them; simultaneous set and err_clr: set wins.
REQ-023 Frame good = no width error in that frame and height == V_ACTIVE; locked asserts at frame_done of the 2nd consecutive good frame; any bad frame deasserts locked and restarts the count.
REQ-024 pix_valid, pix_sof, pix_eol, frame_done SHALL be zero whenever not asserted by the rules above.

Reset
REQ-025 nRST=0 sampled SHALL force state SYNC, all counters 0, all outputs 0, including mid-frame; first valid pixel only after a full V_GAP_MIN gap following release.

Structure
REQ-026 Package lcd_rx_pkg SHALL hold FSM state enum, default timing constants and counter widths.
REQ-027 Measurement/lock logic (REQ-020..023) SHALL be a sub-module lcd_rx_lock; edge detect, counters and FSM in lcd_de_rx.

Verification
REQ-028 Reset, then 3 frames of 272 x 480-pixel lines, 45-clock H gap, 3000-clock V gap -> first frame ignored (SYNC); frames 2-3 emit 130560 valid pixels each, locked=1 after frame 3 frame_done, no errors.
REQ-029 Color-bar data, check pixel at x=479,y=271 -> pix_eol=1, pix_data equals input delayed 2 clocks.
REQ-030 One 479-pixel line in a locked stream -> err_width=1, meas_width stays 480 only if last line is 480, locked=0 at that frame_done.
REQ-031 Frame with 271 lines -> meas_height=271, err_height=1, locked drops; err_clr pulse coinciding with a new error -> flag remains 1.
REQ-032 nRST asserted at line 100 -> all outputs 0 next cycle; after release, partial frame produces no pix_valid until a 1024-clock gap.
REQ-033 DE low run of 1023 clocks inside ACTIVE -> no frame_done; 1024 clocks -> frame_done pulse.
